// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, HALT capture and drain sequencing,
// plus a retired-instruction counter for the debug unit.
module ex_mem_pipe_reg #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_ex,
    input  logic [DATA_W-1:0] alu_result_ex,
    input  logic [DATA_W-1:0] store_data_ex,
    input  logic [4:0]        rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              mem_write_ex,
    input  logic              mem_to_reg_ex,
    input  logic [2:0]        size_ex,
    input  logic              halt_ex,
    output logic              valid_ex_m,
    output logic [DATA_W-1:0] alu_result_ex_m,
    output logic [DATA_W-1:0] store_data_ex_m,
    output logic [4:0]        rd_ex_m,
    output logic              reg_write_ex_m,
    output logic              mem_read_ex_m,
    output logic              mem_write_ex_m,
    output logic              mem_to_reg_ex_m,
    output logic [2:0]        size_ex_m,
    output logic              halt_ex_m,
    output logic              pipe_drained,
    output logic [CNT_W-1:0]  instr_cnt
);

    // state    | meaning
    // ST_RUN   | normal operation, stage loads/stalls/flushes
    // ST_DRAIN | HALT captured, bubbles loaded while MEM/WB empty out
    // ST_DONE  | pipeline empty, stage frozen as bubble until reset
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [2:0]        size_q, size_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    logic bubble;
    logic load;

    always_comb begin
        bubble = flush || (state_q != ST_RUN);
        load   = !bubble && !stall;
    end

    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        size_d       = size_q;
        halt_d       = halt_q;
        instr_cnt_d  = instr_cnt_q;
        if (bubble) begin
            valid_d      = 1'b0;
            alu_result_d = '0;
            store_data_d = '0;
            rd_d         = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            size_d       = '0;
            halt_d       = 1'b0;
        end else if (load) begin
            valid_d      = valid_ex;
            alu_result_d = alu_result_ex;
            store_data_d = store_data_ex;
            rd_d         = rd_ex;
            reg_write_d  = reg_write_ex  & valid_ex;
            mem_read_d   = mem_read_ex   & valid_ex;
            mem_write_d  = mem_write_ex  & valid_ex;
            mem_to_reg_d = mem_to_reg_ex & valid_ex;
            size_d       = size_ex;
            halt_d       = halt_ex       & valid_ex;
            instr_cnt_d  = instr_cnt_q + {{(CNT_W-1){1'b0}}, valid_ex};
        end
    end

    // Drain sequencing advances every edge once HALT is in, flush or not.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (load && valid_ex && halt_ex) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 4'd0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 4'd1;
                if (drain_cnt_d == 4'(DRAIN_CYCLES)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            size_q       <= '0;
            halt_q       <= 1'b0;
            instr_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            size_q       <= size_d;
            halt_q       <= halt_d;
            instr_cnt_q  <= instr_cnt_d;
        end
    end

    assign valid_ex_m      = valid_q;
    assign alu_result_ex_m = alu_result_q;
    assign store_data_ex_m = store_data_q;
    assign rd_ex_m         = rd_q;
    assign reg_write_ex_m  = reg_write_q;
    assign mem_read_ex_m   = mem_read_q;
    assign mem_write_ex_m  = mem_write_q;
    assign mem_to_reg_ex_m = mem_to_reg_q;
    assign size_ex_m       = size_q;
    assign halt_ex_m       = halt_q;
    assign pipe_drained    = (state_q == ST_DONE);
    assign instr_cnt       = instr_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed scenarios plus randomized traffic against
// a behavioural model of the MEM stage, HALT age and retired count.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid_ex;
    logic [31:0] alu_result_ex, store_data_ex;
    logic [4:0]  rd_ex;
    logic        reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex;
    logic [2:0]  size_ex;
    logic        halt_ex;

    logic        a_valid, a_rw, a_mr, a_mw, a_m2r, a_halt, a_drained;
    logic [31:0] a_alu, a_st;
    logic [4:0]  a_rd;
    logic [2:0]  a_size;
    logic [31:0] a_cnt;

    logic        b_valid, b_rw, b_mr, b_mw, b_m2r, b_halt, b_drained;
    logic [31:0] b_alu, b_st;
    logic [4:0]  b_rd;
    logic [2:0]  b_size;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DATA_W(32), .DRAIN_CYCLES(2), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_ex(valid_ex),
        .alu_result_ex(alu_result_ex), .store_data_ex(store_data_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .size_ex(size_ex), .halt_ex(halt_ex),
        .valid_ex_m(a_valid), .alu_result_ex_m(a_alu), .store_data_ex_m(a_st), .rd_ex_m(a_rd),
        .reg_write_ex_m(a_rw), .mem_read_ex_m(a_mr), .mem_write_ex_m(a_mw),
        .mem_to_reg_ex_m(a_m2r), .size_ex_m(a_size), .halt_ex_m(a_halt),
        .pipe_drained(a_drained), .instr_cnt(a_cnt)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .DRAIN_CYCLES(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_ex(valid_ex),
        .alu_result_ex(alu_result_ex), .store_data_ex(store_data_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .size_ex(size_ex), .halt_ex(halt_ex),
        .valid_ex_m(b_valid), .alu_result_ex_m(b_alu), .store_data_ex_m(b_st), .rd_ex_m(b_rd),
        .reg_write_ex_m(b_rw), .mem_read_ex_m(b_mr), .mem_write_ex_m(b_mw),
        .mem_to_reg_ex_m(b_m2r), .size_ex_m(b_size), .halt_ex_m(b_halt),
        .pipe_drained(b_drained), .instr_cnt(b_cnt)
    );

    localparam int DRAIN = 2;

    // Model: contents of the MEM slot, edges since HALT was captured (-1 = none), retired count
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_halt;
    logic [31:0] m_alu, m_st;
    logic [4:0]  m_rd;
    logic [2:0]  m_size;
    logic [31:0] m_cnt;
    int          halt_age;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_halt = 0;
        m_alu = 0; m_st = 0; m_rd = 0; m_size = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_bubble();
            m_cnt = 0;
            halt_age = -1;
        end else if (flush || halt_age >= 0) begin
            model_bubble();
            if (halt_age >= 0) halt_age++;
        end else if (!stall) begin
            m_valid = valid_ex;
            m_alu   = alu_result_ex;
            m_st    = store_data_ex;
            m_rd    = rd_ex;
            m_rw    = reg_write_ex && valid_ex;
            m_mr    = mem_read_ex && valid_ex;
            m_mw    = mem_write_ex && valid_ex;
            m_m2r   = mem_to_reg_ex && valid_ex;
            m_size  = size_ex;
            m_halt  = halt_ex && valid_ex;
            if (valid_ex) m_cnt = m_cnt + 1;
            if (valid_ex && halt_ex) halt_age = 0;
        end
    endtask

    task automatic compare_all();
        logic exp_drained;
        exp_drained = (halt_age >= DRAIN);
        chk("valid",      a_valid,   m_valid);
        chk("alu",        a_alu,     m_alu);
        chk("store",      a_st,      m_st);
        chk("rd",         a_rd,      m_rd);
        chk("reg_write",  a_rw,      m_rw);
        chk("mem_read",   a_mr,      m_mr);
        chk("mem_write",  a_mw,      m_mw);
        chk("mem_to_reg", a_m2r,     m_m2r);
        chk("size",       a_size,    m_size);
        chk("halt",       a_halt,    m_halt);
        chk("drained",    a_drained, exp_drained);
        chk("instr_cnt",  a_cnt,     m_cnt);
        chk("w4_valid",   b_valid,   m_valid);
        chk("w4_alu",     b_alu,     m_alu);
        chk("w4_store",   b_st,      m_st);
        chk("w4_rd",      b_rd,      m_rd);
        chk("w4_ctrl",    {b_rw, b_mr, b_mw, b_m2r, b_halt}, {m_rw, m_mr, m_mw, m_m2r, m_halt});
        chk("w4_size",    b_size,    m_size);
        chk("w4_drained", b_drained, exp_drained);
        chk("w4_cnt",     b_cnt,     m_cnt[3:0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        rst_n = 1; stall = 0; flush = 0; valid_ex = 0;
        alu_result_ex = 0; store_data_ex = 0; rd_ex = 0;
        reg_write_ex = 0; mem_read_ex = 0; mem_write_ex = 0; mem_to_reg_ex = 0;
        size_ex = 0; halt_ex = 0;
    endtask

    task automatic rand_data();
        valid_ex      = ($urandom_range(0, 3) != 0);
        alu_result_ex = $urandom;
        store_data_ex = $urandom;
        rd_ex         = 5'($urandom);
        reg_write_ex  = 1'($urandom);
        mem_read_ex   = 1'($urandom);
        mem_write_ex  = 1'($urandom);
        mem_to_reg_ex = 1'($urandom);
        size_ex       = 3'($urandom);
        halt_ex       = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        logic [31:0] held_cnt;
        clear_inputs();
        m_cnt = 0;
        halt_age = -1;
        model_bubble();

        // reset with random inputs
        rst_n = 0;
        rand_data();
        step();
        rand_data();
        step();
        chk("reset_drained", a_drained, 1'b0);
        chk("reset_cnt", a_cnt, 32'd0);
        chk("reset_valid", a_valid, 1'b0);

        // simple load
        clear_inputs();
        valid_ex = 1; rd_ex = 5'd9; reg_write_ex = 1; alu_result_ex = 32'h1234;
        step();
        chk("load_rd", a_rd, 5'd9);
        chk("load_rw", a_rw, 1'b1);
        chk("load_alu", a_alu, 32'h1234);
        chk("load_cnt", a_cnt, 32'd1);

        // stall holds through changing inputs
        for (int i = 0; i < 3; i++) begin
            rand_data();
            halt_ex = 0;
            stall = 1;
            step();
        end
        chk("stall_alu", a_alu, 32'h1234);
        chk("stall_rd", a_rd, 5'd9);
        chk("stall_cnt", a_cnt, 32'd1);
        flush = 1;
        step();
        chk("stflush_valid", a_valid, 1'b0);
        chk("stflush_rw", a_rw, 1'b0);
        chk("stflush_rd", a_rd, 5'd0);

        // invalid instruction gates control
        clear_inputs();
        reg_write_ex = 1; mem_write_ex = 1; rd_ex = 5'd3;
        step();
        chk("inv_rw", a_rw, 1'b0);
        chk("inv_mw", a_mw, 1'b0);
        chk("inv_cnt", a_cnt, 32'd1);

        // HALT capture and drain
        clear_inputs();
        valid_ex = 1; halt_ex = 1; rd_ex = 5'd7; reg_write_ex = 1;
        step();
        chk("halt_n1", a_halt, 1'b1);
        chk("halt_n1_drained", a_drained, 1'b0);
        chk("halt_n1_cnt", a_cnt, 32'd2);
        rand_data();
        valid_ex = 1;
        step();
        chk("halt_n2", a_halt, 1'b0);
        chk("halt_n2_valid", a_valid, 1'b0);
        chk("halt_n2_drained", a_drained, 1'b0);
        rand_data();
        valid_ex = 1;
        step();
        chk("halt_n3_drained", a_drained, 1'b1);
        held_cnt = a_cnt;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            valid_ex = 1;
            stall = 1'($urandom);
            step();
        end
        chk("done_valid", a_valid, 1'b0);
        chk("done_cnt", a_cnt, 32'd2);
        chk("done_drained", a_drained, 1'b1);
        rst_n = 0;
        step();
        chk("done_reset_drained", a_drained, 1'b0);

        // counter wrap on the 4-bit instance
        clear_inputs();
        for (int i = 0; i < 16; i++) begin
            rand_data();
            valid_ex = 1; halt_ex = 0;
            step();
            if (i == 14) chk("w4_cnt15", b_cnt, 4'd15);
        end
        chk("w4_wrap", b_cnt, 4'd0);
        chk("w32_16", a_cnt, 32'd16);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
